// File: rtl/gaussian_pkg.sv
// Shared constants for the 3x3 Gaussian blur.
//   KERNEL_SHIFT : divide-by-16 normalisation of kernel [1 2 1; 2 4 2; 1 2 1]
//   W_*          : kernel weights, all powers of two so they map to shifts
//   sum_width()  : accumulator width for a given pixel width
package gaussian_pkg;

  localparam int KERNEL_SHIFT = 4;

  localparam int W_CORNER = 1;
  localparam int W_EDGE   = 2;
  localparam int W_CENTER = 4;

  // Kernel gain is 16, so four extra bits hold any weighted sum exactly.
  function automatic int sum_width(input int pixel_width);
    return pixel_width + 4;
  endfunction

endpackage

// File: rtl/gaussian_line_buffer.sv
// One image row of storage, indexed by column.
//   clk       : clock
//   wr_en_i   : write wr_data_i at addr_i on the rising edge
//   addr_i    : column index shared by read and write
//   wr_data_i : value stored for this column
//   rd_data_o : combinational read of the value currently held at addr_i
// A read and write at the same index in one cycle returns the old value,
// which is what lets two buffers be chained into a row delay line.
module gaussian_line_buffer
  import gaussian_pkg::*;
#(
  parameter int DEPTH = 48,
  parameter int WIDTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rd_data_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/gaussian_blur_3x3.sv
// Streaming 3x3 Gaussian blur, "valid" convolution (no padding).
//   clk, reset        : single clock, synchronous active-high reset
//   pixel_in_T*       : raster-order input stream (valid/ready)
//   pixel_out_T*      : blurred stream, (IN_ROWS-2) x (IN_COLS-2) per frame
// Frames run back-to-back; the row/col counters alone mark frame edges.
module gaussian_blur_3x3
  import gaussian_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 16,
  parameter int IN_ROWS         = 48,
  parameter int IN_COLS         = 48
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in_TDATA,
  input  logic                       pixel_in_TVALID,
  output logic                       pixel_in_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out_TDATA,
  output logic                       pixel_out_TVALID,
  input  logic                       pixel_out_TREADY
);

  localparam int SUM_W = sum_width(PIXEL_BIT_WIDTH);
  localparam int EXT_W = SUM_W - PIXEL_BIT_WIDTH;
  localparam int ROW_W = $clog2(IN_ROWS);
  localparam int COL_W = $clog2(IN_COLS);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             out_valid_q, out_valid_d;
  logic [PIXEL_BIT_WIDTH-1:0] out_data_q, out_data_d;

  // win_q[row][col]: row 0 is the oldest image row, col 2 the newest column.
  logic signed [PIXEL_BIT_WIDTH-1:0] win_q [3][3];

  logic [PIXEL_BIT_WIDTH-1:0]        lb0_rd, lb1_rd;
  logic signed [PIXEL_BIT_WIDTH-1:0] new_col [3];
  logic signed [PIXEL_BIT_WIDTH-1:0] tap     [3][3];
  logic signed [SUM_W-1:0]           tap_ext [3][3];
  logic signed [SUM_W-1:0]           corner_sum, edge_sum, kernel_sum;
  logic [PIXEL_BIT_WIDTH-1:0]        blur;

  logic in_xfer, out_xfer, emit;

  // Single output register, no skid: accept only when the slot is free or
  // is being drained this cycle.
  assign pixel_in_TREADY = !out_valid_q || pixel_out_TREADY;
  assign in_xfer         = pixel_in_TVALID && pixel_in_TREADY;
  assign out_xfer        = out_valid_q && pixel_out_TREADY;
  // Rows 0-1 and cols 0-1 would mix stale rows or wrap across a row edge.
  assign emit = in_xfer && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  // lb0 delays by one row, lb1 (fed from lb0) by two.
  gaussian_line_buffer #(.DEPTH(IN_COLS), .WIDTH(PIXEL_BIT_WIDTH)) u_lb0 (
    .clk       (clk),
    .wr_en_i   (in_xfer),
    .addr_i    (col_q),
    .wr_data_i (pixel_in_TDATA),
    .rd_data_o (lb0_rd)
  );

  gaussian_line_buffer #(.DEPTH(IN_COLS), .WIDTH(PIXEL_BIT_WIDTH)) u_lb1 (
    .clk       (clk),
    .wr_en_i   (in_xfer),
    .addr_i    (col_q),
    .wr_data_i (lb0_rd),
    .rd_data_o (lb1_rd)
  );

  assign new_col[0] = lb1_rd;
  assign new_col[1] = lb0_rd;
  assign new_col[2] = pixel_in_TDATA;

  // The result is formed from the window as it will look after this
  // shift (cols 1,2 plus the incoming column) so it lands one cycle after
  // the accepting edge.
  for (genvar gi = 0; gi < 3; gi++) begin : g_tap_row
    for (genvar gj = 0; gj < 3; gj++) begin : g_tap_col
      if (gj < 2) begin : g_reg
        assign tap[gi][gj] = win_q[gi][gj+1];
      end else begin : g_new
        assign tap[gi][gj] = new_col[gi];
      end
      assign tap_ext[gi][gj] = {{EXT_W{tap[gi][gj][PIXEL_BIT_WIDTH-1]}}, tap[gi][gj]};
    end
  end

  assign corner_sum = tap_ext[0][0] + tap_ext[0][2] + tap_ext[2][0] + tap_ext[2][2];
  assign edge_sum   = tap_ext[0][1] + tap_ext[1][0] + tap_ext[1][2] + tap_ext[2][1];
  assign kernel_sum = (corner_sum    <<< $clog2(W_CORNER))
                    + (edge_sum      <<< $clog2(W_EDGE))
                    + (tap_ext[1][1] <<< $clog2(W_CENTER));
  // Arithmetic shift floors toward -inf; the quotient always fits the pixel.
  assign blur = PIXEL_BIT_WIDTH'(kernel_sum >>> KERNEL_SHIFT);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_xfer) begin
      if (col_q == COL_W'(IN_COLS - 1)) begin
        col_d = '0;
        if (row_q == ROW_W'(IN_ROWS - 1)) begin
          row_d = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = blur;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q       <= '0;
      col_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      row_q       <= row_d;
      col_q       <= col_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      if (in_xfer) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
          win_q[r][2] <= new_col[r];
        end
      end
    end
  end

  assign pixel_out_TVALID = out_valid_q;
  assign pixel_out_TDATA  = out_data_q;

endmodule

// File: tb/tb_gaussian_blur_3x3.sv
module tb_gaussian_blur_3x3;

  localparam int PW        = 16;
  localparam int R         = 48;
  localparam int C         = 48;
  localparam int OC        = C - 2;
  localparam int FRAME_OUT = (R - 2) * (C - 2);

  localparam int K_CONST = 0;
  localparam int K_IMP   = 1;
  localparam int K_RAMP  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [PW-1:0] pixel_in_TDATA;
  logic          pixel_in_TVALID;
  logic          pixel_in_TREADY;
  logic [PW-1:0] pixel_out_TDATA;
  logic          pixel_out_TVALID;
  logic          pixel_out_TREADY;

  always #5 clk = ~clk;

  gaussian_blur_3x3 #(.PIXEL_BIT_WIDTH(PW), .IN_ROWS(R), .IN_COLS(C)) dut (
    .clk              (clk),
    .reset            (reset),
    .pixel_in_TDATA   (pixel_in_TDATA),
    .pixel_in_TVALID  (pixel_in_TVALID),
    .pixel_in_TREADY  (pixel_in_TREADY),
    .pixel_out_TDATA  (pixel_out_TDATA),
    .pixel_out_TVALID (pixel_out_TVALID),
    .pixel_out_TREADY (pixel_out_TREADY)
  );

  int checks = 0;
  int errors = 0;
  int g_kind [2];
  int g_amp  [2];
  int g_ipos [2];
  int n_out;
  bit abort;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pix_at(input int f, input int r, input int c);
    case (g_kind[f])
      K_CONST: return g_amp[f];
      K_IMP:   return (r == g_ipos[f] && c == g_ipos[f]) ? g_amp[f] : 0;
      default: return c;
    endcase
  endfunction

  // Expected output at stream index idx (frames of FRAME_OUT outputs).
  function automatic int exp_at(input int idx);
    int tab16 [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    int f = idx / FRAME_OUT;
    int k = idx % FRAME_OUT;
    int y = k / OC + 1;
    int x = k % OC + 1;
    int dy, dx;
    case (g_kind[f])
      K_CONST: return g_amp[f];
      K_IMP: begin
        dy = y - g_ipos[f];
        dx = x - g_ipos[f];
        if (dy < -1 || dy > 1 || dx < -1 || dx > 1) return 0;
        if (g_amp[f] == 16) return tab16[(dy + 1) * 3 + dx + 1];
        if (g_amp[f] == -1) return -1;
        return 0;
      end
      default: return x;
    endcase
  endfunction

  task automatic run(input string name, input int nfr, input int in_rand,
                     input int out_rand, input int stall_at, input int max_pix,
                     input int target, input int rate_chk, input int idle_chk);
    n_out = 0;
    abort = 1'b0;
    fork
      begin : drv
        int idx = 0;
        for (int f = 0; f < nfr && idx < max_pix && !abort; f++)
          for (int r = 0; r < R && idx < max_pix && !abort; r++)
            for (int c = 0; c < C && idx < max_pix && !abort; c++) begin
              bit acc = 1'b0;
              int w = 0;
              while (!acc && !abort) begin
                @(posedge clk); #1;
                pixel_in_TVALID = (in_rand != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
                pixel_in_TDATA  = PW'(pix_at(f, r, c));
                @(negedge clk);
                acc = pixel_in_TVALID && pixel_in_TREADY;
                w++;
                if (!acc && w > 400) begin
                  check({name, "_drv_timeout"}, idx, max_pix);
                  abort = 1'b1;
                end
              end
              idx++;
            end
        @(posedge clk); #1;
        pixel_in_TVALID = 1'b0;
      end
      begin : snk
        int cyc = 0;
        int last = 0;
        int vc;
        bit stalled = 1'b0;
        while (n_out < target && !abort) begin
          if (stall_at >= 0 && n_out == stall_at && !stalled) begin
            stalled = 1'b1;
            vc = 0;
            for (int s = 0; s < 200; s++) begin
              @(posedge clk); #1;
              pixel_out_TREADY = 1'b0;
              @(negedge clk);
              if (pixel_out_TVALID) begin
                vc++;
                check({name, "_bp_in_ready"}, int'(pixel_in_TREADY), 0);
                check({name, "_bp_hold"}, int'($signed(pixel_out_TDATA)), exp_at(n_out));
              end
            end
            check({name, "_bp_pending"}, int'(vc >= 190), 1);
          end
          @(posedge clk); #1;
          pixel_out_TREADY = (out_rand != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
          @(negedge clk);
          cyc++;
          if (pixel_out_TVALID) begin
            check({name, "_data"}, int'($signed(pixel_out_TDATA)), exp_at(n_out));
            if (pixel_out_TREADY) begin
              if (rate_chk != 0 && (n_out % OC) != 0) check({name, "_rate"}, cyc - last, 1);
              last = cyc;
              n_out++;
            end
          end
          if (cyc > 30000) begin
            check({name, "_sink_timeout"}, n_out, target);
            abort = 1'b1;
          end
        end
        @(posedge clk); #1;
        pixel_out_TREADY = (idle_chk != 0);
      end
    join
    check({name, "_count"}, n_out, target);
    if (idle_chk != 0) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check({name, "_idle"}, int'(pixel_out_TVALID), 0);
    end
    $display("%s: %0d outputs received", name, n_out);
  endtask

  initial begin
    reset            = 1'b1;
    pixel_in_TVALID  = 1'b0;
    pixel_in_TDATA   = '0;
    pixel_out_TREADY = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_valid", int'(pixel_out_TVALID), 0);
    check("reset_data", int'(pixel_out_TDATA), 0);
    check("reset_in_ready", int'(pixel_in_TREADY), 1);

    g_kind[0] = K_CONST; g_amp[0] = 100;
    run("const100", 1, 0, 0, -1, R * C, FRAME_OUT, 1, 1);

    g_kind[0] = K_IMP; g_amp[0] = 16; g_ipos[0] = 5;
    run("imp16", 1, 0, 0, -1, R * C, FRAME_OUT, 0, 1);

    g_kind[0] = K_CONST; g_amp[0] = -3;
    run("const_m3", 1, 0, 0, -1, R * C, FRAME_OUT, 0, 1);

    g_kind[0] = K_IMP; g_amp[0] = -1; g_ipos[0] = 10;
    run("imp_m1", 1, 0, 0, -1, R * C, FRAME_OUT, 0, 1);

    g_kind[0] = K_IMP; g_amp[0] = 1; g_ipos[0] = 10;
    run("imp_p1", 1, 0, 0, -1, R * C, FRAME_OUT, 0, 1);

    g_kind[0] = K_RAMP;
    run("ramp_rand", 1, 1, 1, -1, R * C, FRAME_OUT, 0, 1);

    g_kind[0] = K_RAMP;
    run("backpressure", 1, 0, 0, 500, R * C, FRAME_OUT, 0, 1);

    // 1000 pixels of a constant-77 frame; the last result is left held.
    g_kind[0] = K_CONST; g_amp[0] = 77;
    run("partial", 1, 0, 0, -1, 1000, 865, 0, 0);
    @(negedge clk);
    check("held_valid", int'(pixel_out_TVALID), 1);
    check("held_data", int'($signed(pixel_out_TDATA)), 77);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pixel_out_TREADY = 1'b1;
    @(negedge clk);
    check("midrst_valid", int'(pixel_out_TVALID), 0);
    check("midrst_data", int'(pixel_out_TDATA), 0);
    check("midrst_in_ready", int'(pixel_in_TREADY), 1);

    g_kind[0] = K_CONST; g_amp[0] = 50;
    g_kind[1] = K_RAMP;
    run("after_reset", 2, 0, 0, -1, 2 * R * C, 2 * FRAME_OUT, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
